sr_receiver: RTL
================

# sr_receiver

Serial-to-parallel receiver for the team's 3-wire shift-register link (sclk / dio / rclk latch). It samples the three link wires, which are asynchronous to `clk`, through synchronizers. It shifts `dio` in LSB-first on every rising edge of `sclk`, and presents the assembled word on a parallel bus when the latch line fires. It sits at the far end of the link, either on the target board or in an FPGA loopback and self-test harness, and reports framing errors.

## Interface
- `WIDTH`, default 16: word width in bits (≥2).
- `SYNC_STAGES`, default 2: synchronizer flops per input (≥2).
- `LATCH_BOTH_EDGES`, default 0: 0 latches on `rclk` rising edge only; 1 latches on both edges, for a toggling latch line.
- `clk` input 1: system clock; all state on its rising edge.
- `rst_n_i` input 1: asynchronous, active-low reset.
- `sclk_i` input 1: link shift clock, asynchronous to `clk`.
- `dio_i` input 1: link serial data, LSB first.
- `rclk_i` input 1: link latch clock, asynchronous to `clk`.
- `data_o` output WIDTH: last latched word.
- `valid_o` output 1: one-cycle pulse, `data_o` and `frame_err_o` updated this cycle.
- `frame_err_o` output 1: latched word was preceded by a shift count ≠ WIDTH.
- `word_cnt_o` output 16: count of latch events, wraps 0xFFFF→0.

## Operation
- Synchronizers:
  - `sclk_i`, `dio_i` and `rclk_i` each pass through SYNC_STAGES flops, plus one history flop per clock line for edge detection.
  - `dio` is delayed identically to `sclk`, so bit and edge stay aligned.
- Arm counter:
  - After reset release, edge detection is disabled for SYNC_STAGES+1 cycles.
  - This prevents pins held high across reset from producing spurious edges.
- Shift register `sh[WIDTH-1:0]`:
  - On each detected `sclk` rise: `sh <= {dio_s, sh[WIDTH-1:1]}`.
  - The first bit shifted ends in bit 0 after WIDTH shifts.
- Bit counter `bcnt`:
  - Width clog2(WIDTH+2).
  - Increments per shift, saturates at WIDTH+1.
  - Cleared on every latch event.
- Latch event: detected `rclk` rise, or either edge when LATCH_BOTH_EDGES=1. On a latch event:
  - `data_o` <= the shift-register value including any shift occurring the same cycle.
  - `valid_o` = 1 for exactly one cycle.
  - `frame_err_o` <= (effective count ≠ WIDTH). The effective count includes a same-cycle shift.
  - `word_cnt_o` += 1.
  - `bcnt` <= 0, or 1 if a shift occurs in the same cycle but is not counted toward this word. Clarification: a same-cycle shift belongs to the word being latched, so `bcnt` <= 0.
- No handshake back-pressure: the consumer must take `data_o` on `valid_o`; `data_o` holds until the next latch.
- More than WIDTH shifts before a latch: `data_o` holds the last WIDTH bits shifted; `frame_err_o`=1.
- Latch with zero shifts: `data_o` = unchanged `sh`; `frame_err_o`=1.

## Timing
- Reset values: `data_o`=0, `valid_o`=0, `frame_err_o`=0, `word_cnt_o`=0, `sh`=0, `bcnt`=0, all synchronizer and history flops 0.
- Reset asserted mid-word: the partial word is discarded. The next word counts from bit 0 after the arm period.
- Input-to-detect latency: a pin edge is detected SYNC_STAGES+1 `clk` cycles after it is sampled.
- `rclk` rising edge on the pin → `valid_o` high SYNC_STAGES+1 cycles later. This is 3 cycles at default.
- Input constraints:
  - Link `sclk` high and low phases each ≥ SYNC_STAGES `clk` periods.
  - `dio` is stable from SYNC_STAGES cycles before to 1 cycle after the `sclk` rise.
  - `rclk` edges are ≥ 2 `clk` periods apart.
  - Faster inputs produce undefined data but must not hang the block.
- Single clock domain after the synchronizers; no combinational path from input to output.

## Test plan
- Nominal word:
  - Stimulus: shift 0xA5C3 LSB-first (sclk period 8 `clk`), then an `rclk` rise.
  - Required response: `data_o`=0xA5C3, `valid_o` one cycle, exactly 3 cycles after the pin edge; `frame_err_o`=0; `word_cnt_o`=1.
- Short and long frames:
  - 15 shifts then latch → `frame_err_o`=1.
  - 17 shifts of 0x1_FFFE pattern (bit 0 first) then latch → `data_o` = last 16 bits; `frame_err_o`=1.
  - Following clean word → `frame_err_o`=0.
- Simultaneous events: the 16th `sclk` rise and the `rclk` rise arrive in the same `clk` cycle → the word includes the 16th bit; `frame_err_o`=0.
- Both-edge mode: LATCH_BOTH_EDGES=1, two back-to-back words 0x0001 and 0x8000 with toggling `rclk` → two `valid_o` pulses with the correct data; `word_cnt_o`=2.
- Reset cases:
  - Reset asserted after 7 bits, released with `sclk_i`=1 held → no spurious shift.
  - Next full word 0x1234 received with `frame_err_o`=0.
- Counter wrap: 65536 latch events → `word_cnt_o` returns to 0.

Source files
------------

// File: rtl/sr_receiver.sv
// sr_receiver
// Serial-to-parallel receiver for the 3-wire shift-register link
// (sclk / dio / rclk latch). The three link wires are asynchronous to clk
// and pass through synchronizers. The block shifts dio in LSB-first on
// each sclk rise. On a latch event it presents the assembled word and flags
// framing errors.
//
// Parameters:
//   WIDTH            word width in bits (>= 2)
//   SYNC_STAGES      synchronizer flops per link input (>= 2)
//   LATCH_BOTH_EDGES 0: latch on rclk rise only, 1: latch on either rclk edge
//
// Ports:
//   clk          system clock, all state on its rising edge
//   rst_n_i      asynchronous active-low reset
//   sclk_i       link shift clock (async)
//   dio_i        link serial data, LSB first (async)
//   rclk_i       link latch clock (async)
//   data_o       last latched word, held until the next latch
//   valid_o      one-cycle pulse when data_o / frame_err_o update
//   frame_err_o  latched word was preceded by a shift count other than WIDTH
//   word_cnt_o   number of latch events, wraps 0xFFFF -> 0
module sr_receiver #(
  parameter int WIDTH            = 16,
  parameter int SYNC_STAGES      = 2,
  parameter int LATCH_BOTH_EDGES = 0
) (
  input  logic             clk,
  input  logic             rst_n_i,
  input  logic             sclk_i,
  input  logic             dio_i,
  input  logic             rclk_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             frame_err_o,
  output logic [15:0]      word_cnt_o
);

  localparam int BW = $clog2(WIDTH + 2);
  localparam int AW = $clog2(SYNC_STAGES + 2);

  localparam logic [BW-1:0] BCNT_MAX  = BW'(WIDTH + 1);
  localparam logic [BW-1:0] BCNT_FULL = BW'(WIDTH);
  localparam logic [AW-1:0] ARM_DONE  = AW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] dio_sync;
  logic [SYNC_STAGES-1:0] rclk_sync;
  logic                   sclk_hist;
  logic                   rclk_hist;

  logic [AW-1:0]          arm_cnt;
  logic                   armed;

  logic                   sclk_s;
  logic                   dio_s;
  logic                   rclk_s;
  logic                   sclk_rise;
  logic                   rclk_evt;
  logic                   latch_evt;

  logic [WIDTH-1:0]       sh;
  logic [WIDTH-1:0]       sh_next;
  logic [BW-1:0]          bcnt;
  logic [BW-1:0]          bcnt_next;

  // Synchronizer chains plus one history flop per clock line. dio goes
  // through a chain of the same depth as sclk, so the bit seen at the
  // synchronized sclk rise is the one that was on the pin at the raw rise.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sclk_sync <= '0;
      dio_sync  <= '0;
      rclk_sync <= '0;
      sclk_hist <= 1'b0;
      rclk_hist <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      dio_sync  <= {dio_sync[SYNC_STAGES-2:0], dio_i};
      rclk_sync <= {rclk_sync[SYNC_STAGES-2:0], rclk_i};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      rclk_hist <= rclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign dio_s  = dio_sync[SYNC_STAGES-1];
  assign rclk_s = rclk_sync[SYNC_STAGES-1];

  // Arm counter: the history flops reset to 0. A pin held high through
  // reset would otherwise look like a rising edge once the chain fills.
  // Edge detection stays off until the chain and history have settled.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      arm_cnt <= '0;
    end else if (arm_cnt != ARM_DONE) begin
      arm_cnt <= arm_cnt + AW'(1);
    end
  end

  assign armed     = (arm_cnt == ARM_DONE);
  assign sclk_rise = armed & sclk_s & ~sclk_hist;
  assign rclk_evt  = (LATCH_BOTH_EDGES != 0) ? (rclk_s ^ rclk_hist)
                                             : (rclk_s & ~rclk_hist);
  assign latch_evt = armed & rclk_evt;

  // Shift register and bit count after this cycle's shift. A latch in the
  // same cycle uses these values, so a simultaneous last bit belongs to the
  // word being latched.
  always_comb begin
    sh_next   = sh;
    bcnt_next = bcnt;
    if (sclk_rise) begin
      sh_next = {dio_s, sh[WIDTH-1:1]};
      if (bcnt != BCNT_MAX) begin
        bcnt_next = bcnt + BW'(1);
      end
    end
  end

  // Word assembly and latch. bcnt saturates at WIDTH+1, so any overlong
  // frame still reads as "not WIDTH" however many extra bits arrived.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sh          <= '0;
      bcnt        <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      word_cnt_o  <= '0;
    end else begin
      sh <= sh_next;
      if (latch_evt) begin
        data_o      <= sh_next;
        valid_o     <= 1'b1;
        frame_err_o <= (bcnt_next != BCNT_FULL);
        word_cnt_o  <= word_cnt_o + 16'd1;
        bcnt        <= '0;
      end else begin
        valid_o <= 1'b0;
        bcnt    <= bcnt_next;
      end
    end
  end

endmodule
